// File: rtl/codemem_pingpong.sv
// Ping-pong instruction memory: CPU fetches from the active bank while the loader fills the shadow bank; swap on wr_done + cpu_idle.
// Latency: fetch 1 cycle (2 with CODEMEM_OUTREG_EN defined, adds a BRAM output register stage); swap >= 1 cycle after wr_done.
// Backpressure: wr_ready drops while a swap is pending; refused or out-of-range writes set sticky wr_err. Read path stalls on en=0.
module codemem_pingpong #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  wr_done,
    output logic                  wr_ready,
    output logic                  wr_err,
    input  logic                  cpu_idle,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  active_bank,
    output logic                  swap_pending,
    output logic                  program_valid
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  active_bank_q, active_bank_d;
    logic                  program_valid_q, program_valid_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_vld1_q, rd_vld1_d;
    logic [DATA_WIDTH-1:0] rd_dat1_q, rd_dat1_d;

    logic [DATA_WIDTH-1:0] bank0_mem [DEPTH];
    logic [DATA_WIDTH-1:0] bank1_mem [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_accept;
    logic                  wr_drop;
    logic                  swap;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Range checks use one extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign wr_accept   = wr_en && wr_in_range && (state_q == ST_LOAD);
    assign wr_drop     = wr_en && !wr_accept;
    assign swap        = (state_q == ST_WAIT) && cpu_idle;

    // Writes always target the shadow bank, i.e. the one not being fetched from.
    always_ff @(posedge clk) begin
        if (wr_accept && active_bank_q) begin
            bank0_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !active_bank_q) begin
            bank1_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_word = active_bank_q ? bank1_mem[rd_idx] : bank0_mem[rd_idx];

    always_comb begin
        state_d         = state_q;
        active_bank_d   = active_bank_q;
        program_valid_d = program_valid_q;
        wr_err_d        = wr_err_q;
        case (state_q)
            ST_LOAD: begin
                if (wr_done) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                if (swap) begin
                    state_d         = ST_LOAD;
                    active_bank_d   = ~active_bank_q;
                    program_valid_d = 1'b1;
                    wr_err_d        = 1'b0;
                end
            end
        endcase
        // A drop on the swap edge is still reported against the new load.
        if (wr_drop) begin
            wr_err_d = 1'b1;
        end
    end

    always_comb begin
        rd_vld1_d = rd_vld1_q;
        rd_dat1_d = rd_dat1_q;
        if (en) begin
            rd_vld1_d = rd_en;
            if (rd_en) begin
                rd_dat1_d = rd_in_range ? rd_word : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            active_bank_q   <= 1'b0;
            program_valid_q <= 1'b0;
            wr_err_q        <= 1'b0;
            rd_vld1_q       <= 1'b0;
            rd_dat1_q       <= '0;
        end else begin
            state_q         <= state_d;
            active_bank_q   <= active_bank_d;
            program_valid_q <= program_valid_d;
            wr_err_q        <= wr_err_d;
            rd_vld1_q       <= rd_vld1_d;
            rd_dat1_q       <= rd_dat1_d;
        end
    end

`ifdef CODEMEM_OUTREG_EN
    logic                  rd_vld2_q, rd_vld2_d;
    logic [DATA_WIDTH-1:0] rd_dat2_q, rd_dat2_d;

    always_comb begin
        rd_vld2_d = rd_vld2_q;
        rd_dat2_d = rd_dat2_q;
        if (en) begin
            rd_vld2_d = rd_vld1_q;
            rd_dat2_d = rd_dat1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld2_q <= 1'b0;
            rd_dat2_q <= '0;
        end else begin
            rd_vld2_q <= rd_vld2_d;
            rd_dat2_q <= rd_dat2_d;
        end
    end

    assign rd_data  = rd_dat2_q;
    assign rd_valid = rd_vld2_q;
`else
    assign rd_data  = rd_dat1_q;
    assign rd_valid = rd_vld1_q;
`endif

    assign wr_ready      = (state_q == ST_LOAD);
    assign swap_pending  = (state_q == ST_WAIT);
    assign wr_err        = wr_err_q;
    assign active_bank   = active_bank_q;
    assign program_valid = program_valid_q;

endmodule

// File: tb/tb_codemem_pingpong.sv
// Randomized + directed bench for codemem_pingpong against a bank/array reference model.
module tb_codemem_pingpong;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 256;
`ifdef CODEMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_done = 1'b0;
    logic          wr_ready;
    logic          wr_err;
    logic          cpu_idle = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          active_bank;
    logic          swap_pending;
    logic          program_valid;

    codemem_pingpong #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done),
        .wr_ready(wr_ready), .wr_err(wr_err), .cpu_idle(cpu_idle),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .active_bank(active_bank), .swap_pending(swap_pending), .program_valid(program_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: two plain arrays plus a fetch pipeline of LAT entries.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            m_active;
    bit            m_loading;
    bit            m_pvalid;
    bit            m_err;
    logic [DW-1:0] p_data  [LAT];
    bit            p_vld   [LAT];
    bit            p_known [LAT];

    task automatic model_reset();
        m_active  = 0;
        m_loading = 1;
        m_pvalid  = 0;
        m_err     = 0;
        for (int s = 0; s < LAT; s++) begin
            p_data[s] = '0; p_vld[s] = 0; p_known[s] = 1;
        end
    endtask

    task automatic model_edge();
        bit swap_now = !m_loading && cpu_idle;
        bit drop     = wr_en && !(m_loading && int'(wr_addr) < DEPTH);
        if (en) begin
            for (int s = LAT - 1; s > 0; s--) begin
                p_vld[s] = p_vld[s-1]; p_data[s] = p_data[s-1]; p_known[s] = p_known[s-1];
            end
            p_vld[0] = rd_en;
            if (rd_en) begin
                if (int'(rd_addr) < DEPTH) begin
                    p_data[0]  = m_mem[m_active][rd_addr];
                    p_known[0] = m_known[m_active][rd_addr];
                end else begin
                    p_data[0]  = '0;
                    p_known[0] = 1;
                end
            end
        end
        if (wr_en && !drop) begin
            m_mem[1 - m_active][wr_addr]   = wr_data;
            m_known[1 - m_active][wr_addr] = 1;
        end
        if (m_loading) begin
            if (wr_done) m_loading = 0;
        end else if (swap_now) begin
            m_loading = 1;
            m_active  = 1 - m_active;
            m_pvalid  = 1;
            m_err     = 0;
        end
        if (drop) m_err = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, DW'(rd_valid), DW'(p_vld[LAT-1]));
        if (p_known[LAT-1]) check({tag, "_data"}, rd_data, p_data[LAT-1]);
        check({tag, "_bank"}, DW'(active_bank), DW'(m_active));
        check({tag, "_wrdy"}, DW'(wr_ready), DW'(m_loading));
        check({tag, "_pend"}, DW'(swap_pending), DW'(!m_loading));
        check({tag, "_err"}, DW'(wr_err), DW'(m_err));
        check({tag, "_pvalid"}, DW'(program_valid), DW'(m_pvalid));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        cycle("wr");
        wr_en = 0;
    endtask

    task automatic do_swap();
        wr_done = 1; cycle("done"); wr_done = 0;
        cpu_idle = 1; cycle("swap"); cpu_idle = 0;
    endtask

    task automatic fetch(input int a);
        rd_en = 1; rd_addr = AW'(a);
        repeat (LAT) cycle("fetch");
    endtask

    initial begin
        model_reset();
        #1 rst_n = 0;
        #1 check_all("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1; en = 1;

        // Basic load, swap and fetch
        for (int i = 0; i < 4; i++) wr(i, DW'(64'h1111 * (i + 1)));
        wr_done = 1; cycle("done1"); wr_done = 0;
        check("tp_pending", DW'(swap_pending), 64'd1);
        cpu_idle = 1; cycle("swap1"); cpu_idle = 0;
        check("tp_bank1", DW'(active_bank), 64'd1);
        check("tp_pvalid", DW'(program_valid), 64'd1);
        fetch(2);
        check("tp_rd2", rd_data, 64'h3333);
        check("tp_rd2_vld", DW'(rd_valid), 64'd1);

        // Concurrent load of bank 0 while fetching bank 1, then gated swap
        rd_addr = '0;
        wr(0, 64'hAAAA);
        wr(5, 64'h5555);
        cycle("conc");
        check("tp_conc_old", rd_data, 64'h1111);
        wr_done = 1; cycle("done2"); wr_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin wr_en = 1; wr_addr = AW'(5); wr_data = 64'hDEAD; end
            cycle("gate");
            wr_en = 0;
            check("tp_gate_bank", DW'(active_bank), 64'd1);
            check("tp_gate_wrdy", DW'(wr_ready), 64'd0);
        end
        check("tp_gate_err", DW'(wr_err), 64'd1);
        cpu_idle = 1; cycle("swap2"); cpu_idle = 0;
        check("tp_swap_bank", DW'(active_bank), 64'd0);
        check("tp_swap_errclr", DW'(wr_err), 64'd0);
        check("tp_swap_edge", rd_data, 64'h1111);
        repeat (LAT) cycle("post");
        check("tp_new_bank", rd_data, 64'hAAAA);
        fetch(5);
        check("tp_drop_kept", rd_data, 64'h5555);

        // Boundaries
        wr(256, 64'hBAD);
        check("tp_oob_err", DW'(wr_err), 64'd1);
        fetch(300);
        check("tp_oob_rd", rd_data, 64'd0);
        check("tp_oob_vld", DW'(rd_valid), 64'd1);
        wr_en = 1; wr_addr = AW'(255); wr_data = 64'h255255; wr_done = 1;
        cycle("wr_done_same");
        wr_en = 0; wr_done = 0;
        cpu_idle = 1; cycle("swap3"); cpu_idle = 0;
        fetch(0);
        check("tp_oob_noalias", rd_data, 64'h1111);
        fetch(255);
        check("tp_last_word", rd_data, 64'h255255);

        // Clock-enable freeze with concurrent write
        en = 0;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(10 + i);
            if (i == 0) begin wr_en = 1; wr_addr = AW'(7); wr_data = 64'h7777; end
            cycle("en0");
            wr_en = 0;
            check("tp_en0_data", rd_data, 64'h255255);
            check("tp_en0_vld", DW'(rd_valid), 64'd1);
        end
        en = 1;
        do_swap();
        fetch(7);
        check("tp_en0_write", rd_data, 64'h7777);

        // Async reset in WAIT_SWAP; bank 1 contents survive
        wr_done = 1; cycle("done4"); wr_done = 0;
        #2 rst_n = 0;
        #1 model_reset();
        check_all("arst");
        check("tp_arst_wrdy", DW'(wr_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1;
        do_swap();
        check("tp_arst_bank", DW'(active_bank), 64'd1);
        fetch(2);
        check("tp_arst_keep", rd_data, 64'h3333);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, 279));
            wr_data  = {$urandom, $urandom};
            wr_done  = ($urandom_range(0, 19) == 0);
            cpu_idle = ($urandom_range(0, 3) == 0);
            rd_en    = $urandom_range(0, 1) == 1;
            rd_addr  = AW'($urandom_range(0, 279));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codemem_pingpong.md
Name: codemem_pingpong

Overview:
- Double-buffered (ping-pong) instruction memory for the BPF VM.
- The CPU fetches from the active bank. The host/loader writes a new program into the shadow bank at the same time.
- On loader completion, the banks swap atomically once the CPU reports idle.
- Each bank maps to simple-dual-port BRAM. Generalises the single-bank code RAM with configurable depth, a write handshake, fetch valid tracking and an optional output register.

Parameters:
- ADDR_WIDTH, 10, width of wr_addr/rd_addr.
- DATA_WIDTH, 64, instruction word width.
- DEPTH, 256, words per bank. Legal range 2..2**ADDR_WIDTH; each bank implemented as DEPTH x DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable for the read path only
- wr_addr  in  ADDR_WIDTH  shadow-bank write address
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write strobe; accepted only when wr_ready=1
- wr_done  in  1  pulse: loader finished the program in the shadow bank
- wr_ready  out  1  shadow bank accepts writes
- wr_err  out  1  sticky: write dropped (wr_ready=0 or wr_addr>=DEPTH)
- cpu_idle  in  1  CPU not executing; swap permitted
- rd_addr  in  ADDR_WIDTH  fetch address (active bank)
- rd_en  in  1  fetch request
- rd_data  out  DATA_WIDTH  fetched instruction
- rd_valid  out  1  rd_data holds the result of an accepted fetch
- active_bank  out  1  bank currently serving fetches
- swap_pending  out  1  program loaded, waiting for cpu_idle
- program_valid  out  1  at least one swap has completed since reset

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD, active_bank=0, wr_ready=1, wr_err=0, swap_pending=0, program_valid=0, rd_valid=0, rd_data=0.
  - RAM contents are not reset.
- FSM state LOAD:
  - wr_ready=1. Each cycle with wr_en=1 and wr_addr<DEPTH writes bank[~active_bank][wr_addr] on that edge.
  - wr_done=1 -> WAIT_SWAP. A write in the same cycle as wr_done is still performed.
- FSM state WAIT_SWAP:
  - wr_ready=0, swap_pending=1. wr_done is ignored.
  - Condition for swap: cpu_idle=1 on an edge.
  - On swap, same edge: active_bank toggles, program_valid<=1, wr_err<=0, state -> LOAD.
  - Minimum latency wr_done->swap is 1 cycle; cpu_idle in the wr_done cycle does not swap.
- Dropped writes:
  - wr_en in WAIT_SWAP, or wr_addr>=DEPTH in any state: no RAM change; wr_err<=1 next edge.
  - Out-of-range writes never alias into the bank.
- Read path:
  - Gated by en. With en=0, rd_data and rd_valid hold their values and rd_en is ignored.
  - With en=1: rd_valid<=rd_en.
  - With en=1 and rd_en=1: rd_data<=bank[active_bank][rd_addr], or 0 if rd_addr>=DEPTH.
  - With en=1 and rd_en=0: rd_data holds.
  - Latency is 1 cycle.
- Swap/read ordering: a fetch issued on the swap edge reads the pre-swap bank, because active_bank is registered. The first fetch from the new bank is the one issued the cycle after.
- Write path is independent of en. Writes to the shadow bank never affect rd_data.
- A fetch with program_valid=0 still returns bank contents (undefined); consumers must gate on program_valid.

Optional Feature:
- Macro: CODEMEM_OUTREG_EN.
- Defined:
  - Adds one output pipeline stage (BRAM output register); read latency is 2 cycles.
  - rd_valid is delayed to match; both stages share en.
  - A swap does not flush in-flight reads; they complete with pre-swap data.
  - Reset clears both stages to 0.
- Undefined: latency is 1 cycle as above.

Test Plan:
- Reset, then LOAD writes of addr 0..3 with 0x1111..0x4444, then wr_done, then cpu_idle=1 for 1 cycle:
  - swap_pending=1 one cycle after wr_done; active_bank=1 and program_valid=1 after swap.
  - Fetches of addr 2 return 0x3333 with rd_valid one cycle later (two cycles with CODEMEM_OUTREG_EN).
- Concurrent load/fetch: while fetching bank 1 addr 0 (0x1111) every cycle, write addr 0=0xAAAA to bank 0:
  - rd_data stays 0x1111 until the swap.
  - The first fetch issued after the swap edge returns 0xAAAA.
- Swap gating: wr_done with cpu_idle=0 for 10 cycles:
  - active_bank is unchanged and wr_ready=0 throughout.
  - wr_en at addr 5 during this window sets wr_err=1 and leaves the RAM unchanged.
  - cpu_idle=1 then swaps and clears wr_err.
- Boundary, DEPTH=256:
  - Write to wr_addr=256 -> wr_err=1 and bank addr 0 is unchanged.
  - Fetch of rd_addr=300 -> rd_data=0 with rd_valid=1.
  - wr_en and wr_done in the same cycle at addr 255 -> that word is written.
- en=0 for 3 cycles with rd_en=1 and changing rd_addr:
  - rd_data and rd_valid are frozen.
  - Writes during en=0 still land, verified by a later fetch after swap.
- Assert rst_n low mid-WAIT_SWAP:
  - All outputs return to reset values immediately (asynchronously).
  - After release, active_bank=0 and the shadow bank (bank 1) contents are retained, readable after a new wr_done plus swap.
